// File: rtl/spi_cmd_pkg.sv
// rtl/spi_cmd_pkg.sv - opcodes, parser states and reply constants for spi_cmd_ctrl
package spi_cmd_pkg;

  localparam logic [7:0] OP_NOP        = 8'h00;
  localparam logic [7:0] OP_LED_ON     = 8'h01;
  localparam logic [7:0] OP_LED_OFF    = 8'h02;
  localparam logic [7:0] OP_LED_TOGGLE = 8'h03;
  localparam logic [7:0] OP_WRITE      = 8'h10;
  localparam logic [7:0] OP_READ       = 8'h20;

  localparam logic [7:0] ERR_REPLY = 8'hEE;

  typedef enum logic [1:0] {
    S_OP,
    S_WADDR,
    S_WDATA,
    S_RADDR
  } state_e;

endpackage

// File: rtl/spi_cmd_regbank.sv
// rtl/spi_cmd_regbank.sv - NUM_REGS x 8 register bank, one write port, combinational read and range check
module spi_cmd_regbank #(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we_i,
  input  logic [7:0]              addr_i,
  input  logic [7:0]              wdata_i,
  output logic [7:0]              rdata_o,
  output logic                    addr_ok_o,
  output logic [8*NUM_REGS-1:0]   regs_o
);

  logic [8*NUM_REGS-1:0] regs_q;

  assign addr_ok_o = (addr_i < 8'(NUM_REGS));
  assign regs_o    = regs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else if (we_i && addr_ok_o) begin
      for (int k = 0; k < int'(NUM_REGS); k++) begin
        if (addr_i == 8'(k)) regs_q[8*k +: 8] <= wdata_i;
      end
    end
  end

  // Out-of-range addresses read as zero; the caller substitutes its error reply.
  always_comb begin
    rdata_o = '0;
    for (int k = 0; k < int'(NUM_REGS); k++) begin
      if (addr_i == 8'(k)) rdata_o = regs_q[8*k +: 8];
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// rtl/spi_cmd_ctrl.sv - SPI command parser: LED control, register write/read, MISO reply byte
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 4,
  parameter logic [7:0]  STATUS_MAGIC = 8'hA5
) (
  input  logic                  ext_clk,
  input  logic                  rst_n,
  input  logic                  ss_sync,
  input  logic [7:0]            recv_data,
  input  logic                  recv_ready,
  input  logic                  send_ready,
  output logic [7:0]            send_data,
  output logic                  led,
  output logic [8*NUM_REGS-1:0] regs_q,
  output logic [7:0]            err_count,
  output logic                  busy
);

  state_e     state_q, state_d;
  logic       led_q, led_d;
  logic [7:0] err_q, err_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] reply_q, reply_d;
  logic       reply_valid_q, reply_valid_d;
  logic       err_inc;

  logic       rb_we;
  logic [7:0] rb_addr;
  logic [7:0] rb_rdata;
  logic       rb_addr_ok;

  spi_cmd_regbank #(.NUM_REGS(NUM_REGS)) u_regbank (
    .clk       (ext_clk),
    .rst_n     (rst_n),
    .we_i      (rb_we),
    .addr_i    (rb_addr),
    .wdata_i   (recv_data),
    .rdata_o   (rb_rdata),
    .addr_ok_o (rb_addr_ok),
    .regs_o    (regs_q)
  );

  // Writes use the latched address; reads check the address byte as it arrives.
  assign rb_addr = (state_q == S_WDATA) ? addr_q : recv_data;

  always_comb begin
    state_d       = state_q;
    led_d         = led_q;
    addr_d        = addr_q;
    reply_d       = reply_q;
    reply_valid_d = reply_valid_q;
    err_inc       = 1'b0;
    rb_we         = 1'b0;

    if (reply_valid_q && send_ready) reply_valid_d = 1'b0;

    if (ss_sync) begin
      state_d = S_OP;
      if (state_q != S_OP) err_inc = 1'b1;
    end else if (recv_ready) begin
      case (state_q)
        S_OP: begin
          case (recv_data)
            OP_NOP:        ;
            OP_LED_ON:     led_d = 1'b1;
            OP_LED_OFF:    led_d = 1'b0;
            OP_LED_TOGGLE: led_d = ~led_q;
            OP_WRITE:      state_d = S_WADDR;
            OP_READ:       state_d = S_RADDR;
            default:       err_inc = 1'b1;
          endcase
        end
        S_WADDR: begin
          addr_d  = recv_data;
          state_d = S_WDATA;
        end
        S_WDATA: begin
          if (rb_addr_ok) rb_we = 1'b1;
          else            err_inc = 1'b1;
          state_d = S_OP;
        end
        S_RADDR: begin
          reply_d       = rb_addr_ok ? rb_rdata : ERR_REPLY;
          err_inc       = !rb_addr_ok;
          reply_valid_d = 1'b1;
          state_d       = S_OP;
        end
        default: state_d = S_OP;
      endcase
    end

    err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge ext_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OP;
      led_q         <= 1'b1;
      err_q         <= '0;
      addr_q        <= '0;
      reply_q       <= '0;
      reply_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      led_q         <= led_d;
      err_q         <= err_d;
      addr_q        <= addr_d;
      reply_q       <= reply_d;
      reply_valid_q <= reply_valid_d;
    end
  end

  assign send_data = reply_valid_q ? reply_q : STATUS_MAGIC;
  assign led       = led_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_OP);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb/tb_spi_cmd_ctrl.sv - self-checking bench for spi_cmd_ctrl against a frame-level reference model
module tb_spi_cmd_ctrl;
  import spi_cmd_pkg::*;

  localparam int NR = 4;

  logic            ext_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ss_sync = 1'b1;
  logic [7:0]      recv_data = '0;
  logic            recv_ready = 1'b0;
  logic            send_ready = 1'b0;
  logic [7:0]      send_data;
  logic            led;
  logic [8*NR-1:0] regs_q;
  logic [7:0]      err_count;
  logic            busy;

  spi_cmd_ctrl #(.NUM_REGS(NR), .STATUS_MAGIC(8'hA5)) dut (
    .ext_clk    (ext_clk),
    .rst_n      (rst_n),
    .ss_sync    (ss_sync),
    .recv_data  (recv_data),
    .recv_ready (recv_ready),
    .send_ready (send_ready),
    .send_data  (send_data),
    .led        (led),
    .regs_q     (regs_q),
    .err_count  (err_count),
    .busy       (busy)
  );

  always #5 ext_clk = ~ext_clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: bytes of the frame in progress, completed when its length is known.
  logic [7:0] fb[$];
  logic [7:0] mregs[NR];
  logic       mled;
  int         merr;
  logic [7:0] mreply;
  logic       mrv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mflat();
    logic [31:0] f;
    f = '0;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = mregs[k];
    return f;
  endfunction

  task automatic model_reset();
    fb.delete();
    for (int k = 0; k < NR; k++) mregs[k] = '0;
    mled = 1'b1; merr = 0; mreply = '0; mrv = 1'b0;
  endtask

  task automatic bump();
    if (merr < 255) merr++;
  endtask

  task automatic model_step(input logic ss, input logic rr, input logic [7:0] d, input logic sr);
    logic set_rv;
    set_rv = 1'b0;
    if (ss) begin
      if (fb.size() != 0) bump();
      fb.delete();
    end else if (rr) begin
      fb.push_back(d);
      case (fb[0])
        OP_NOP:        fb.delete();
        OP_LED_ON:     begin mled = 1'b1; fb.delete(); end
        OP_LED_OFF:    begin mled = 1'b0; fb.delete(); end
        OP_LED_TOGGLE: begin mled = ~mled; fb.delete(); end
        OP_WRITE: if (fb.size() == 3) begin
          if (fb[1] < NR) mregs[fb[1][1:0]] = fb[2];
          else bump();
          fb.delete();
        end
        OP_READ: if (fb.size() == 2) begin
          if (fb[1] < NR) mreply = mregs[fb[1][1:0]];
          else begin mreply = 8'hEE; bump(); end
          set_rv = 1'b1;
          fb.delete();
        end
        default: begin bump(); fb.delete(); end
      endcase
    end
    if (set_rv) mrv = 1'b1;
    else if (mrv && sr) mrv = 1'b0;
  endtask

  task automatic check_all();
    chk("led", 32'(led), 32'(mled));
    chk("busy", 32'(busy), 32'(fb.size() != 0));
    chk("err_count", 32'(err_count), 32'(merr));
    chk("regs_q", regs_q, mflat());
    chk("send_data", 32'(send_data), 32'(mrv ? mreply : 8'hA5));
  endtask

  task automatic step(input logic ss, input logic rr, input logic [7:0] d, input logic sr);
    @(negedge ext_clk);
    ss_sync = ss; recv_ready = rr; recv_data = d; send_ready = sr;
    model_step(ss, rr, d, sr);
    @(posedge ext_clk);
    #1;
    recv_ready = 1'b0; send_ready = 1'b0;
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b0, 1'b1, d, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;

    model_reset();
    #12;
    check_all();
    chk("rst_led", 32'(led), 32'd1);
    chk("rst_send_data", 32'(send_data), 32'hA5);
    @(negedge ext_clk);
    rst_n = 1'b1;

    // LED opcodes
    step(1'b0, 1'b0, 8'h00, 1'b0);
    send(8'h02); chk("led_off", 32'(led), 32'd0);
    send(8'h03); chk("led_tog1", 32'(led), 32'd1);
    send(8'h03); chk("led_tog2", 32'(led), 32'd0);
    send(8'h01); chk("led_on", 32'(led), 32'd1);
    chk("led_err0", 32'(err_count), 32'd0);

    // Write then read back with the reply held until send_ready
    send(8'h10); send(8'h02); send(8'h5A);
    chk("wr_reg2", 32'(regs_q[23:16]), 32'h5A);
    send(8'h20); send(8'h02);
    chk("rd_reply", 32'(send_data), 32'h5A);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rd_held", 32'(send_data), 32'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("rd_cleared", 32'(send_data), 32'hA5);

    // Bad address and bad opcode
    send(8'h10); send(8'h07); send(8'h11);
    send(8'h20); send(8'h09);
    chk("bad_reply", 32'(send_data), 32'hEE);
    send(8'h7F);
    chk("bad_err3", 32'(err_count), 32'd3);
    chk("bad_regs", regs_q, 32'h005A_0000);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Truncated frame
    send(8'h10); send(8'h01);
    chk("trunc_busy", 32'(busy), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("trunc_idle", 32'(busy), 32'd0);
    chk("trunc_err", 32'(err_count), 32'd4);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    send(8'h03);
    chk("trunc_toggle", 32'(led), 32'd0);

    // Abort coinciding with a data byte, then from S_OP
    send(8'h10); send(8'h00);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    chk("abort_err", 32'(err_count), 32'd5);
    chk("abort_regs", regs_q, 32'h005A_0000);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h33, 1'b0);
    chk("abort_idle_err", 32'(err_count), 32'd5);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 7));
      case (r)
        0: b = 8'h00;
        1: b = 8'h01;
        2: b = 8'h03;
        3: b = 8'h10;
        4: b = 8'h20;
        5: b = 8'($urandom_range(0, 5));
        6: b = 8'($urandom_range(0, 5));
        default: b = 8'($urandom);
      endcase
      step($urandom_range(0, 99) < 4, $urandom_range(0, 2) != 0, b, $urandom_range(0, 3) == 0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b1);

    // Saturation
    step(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 260; i++) send(8'h7F);
    chk("sat_ff", 32'(err_count), 32'hFF);
    send(8'h7F);
    chk("sat_hold", 32'(err_count), 32'hFF);

    // Asynchronous reset in mid-frame
    send(8'h02); send(8'h20); send(8'h01); send(8'h10);
    @(posedge ext_clk);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_err", 32'(err_count), 32'd0);
    @(negedge ext_clk);
    rst_n = 1'b1;
    send(8'h03);
    chk("post_rst_led", 32'(led), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
Name: spi_cmd_ctrl

Overview:
Command sequencer behind spi_slave. Consumes the received byte stream (recv_data/recv_ready), parses 1-3 byte command frames, drives the LED, writes and reads a small register bank, and sets the send_data byte spi_slave shifts out on MISO. Frame boundaries come from the SS line resynchronised into the ext_clk domain. This block replaces the ad-hoc LED decode at top level.

Parameters:
NUM_REGS, 4, number of 8-bit user registers (2..16); addresses 0..NUM_REGS-1
STATUS_MAGIC, 8'hA5, idle value of send_data when no reply is pending

Ports:
ext_clk  in  1  system clock; all logic on posedge
rst_n  in  1  reset, asynchronous assert, active-low
ss_sync  in  1  SPI slave-select, already synchronised to ext_clk; 1 = frame inactive
recv_data  in  8  byte from spi_slave
recv_ready  in  1  one-cycle pulse: recv_data valid
send_ready  in  1  high: spi_slave may latch send_data for the next byte
send_data  out  8  byte for spi_slave to transmit
led  out  1  LED drive
regs_q  out  8*NUM_REGS  flattened register bank; reg k = bits [8k+7:8k]
err_count  out  8  saturating protocol-error counter
busy  out  1  high while parser is not in S_OP

Behaviour:
- Reset (rst_n=0, async): state=S_OP, led=1, regs_q=0, err_count=0, reply_valid=0, send_data=STATUS_MAGIC, busy=0.
- Bytes are consumed only on cycles with recv_ready=1. All register/LED updates land on the same posedge the consumed byte is sampled, so they are visible the next cycle.
- Opcodes in S_OP:
  00 NOP: no effect.
  01 LED_ON: led<=1.  02 LED_OFF: led<=0.  03 LED_TOGGLE: led<=~led.
  10 WRITE: go to S_WADDR.  20 READ: go to S_RADDR.
  Any other value: err_count+1 (saturates at FF), stay in S_OP.
- S_WADDR: latch addr, go to S_WDATA. S_WDATA: if addr<NUM_REGS, regs[addr]<=byte, else err_count+1. Return to S_OP in either case.
- S_RADDR: if addr<NUM_REGS, reply<=regs[addr], else reply<=8'hEE and err_count+1. reply_valid<=1. Return to S_OP.
- Reply path: send_data = reply when reply_valid, otherwise STATUS_MAGIC. Clear reply_valid on the first cycle with send_ready=1 and reply_valid=1 that is not the cycle reply_valid is set. A new READ arriving while reply_valid=1 overwrites reply; there is no error for this case.
- Frame abort: ss_sync=1 forces state<=S_OP on every cycle. If ss_sync=1 and recv_ready=1 in the same cycle, the abort wins: the byte is discarded, and err_count+1 if state was not S_OP (truncated frame). A frame ending in S_OP is not an error.
- Within one SS-low frame, consecutive commands are allowed; the parser returns to S_OP after each command.
- err_count saturates at 8'hFF and never wraps.
- busy = (state != S_OP).
- Reset in mid-frame: all state is cleared asynchronously. Bytes after reset release are parsed as opcodes.

Decomposition:
- Package spi_cmd_pkg: opcode localparams (OP_NOP, OP_LED_ON, OP_LED_OFF, OP_LED_TOGGLE, OP_WRITE, OP_READ), state enum (S_OP, S_WADDR, S_WDATA, S_RADDR), ERR_REPLY=8'hEE.
- Sub-module spi_cmd_regbank: NUM_REGS x 8 storage with write port, combinational read port and range check (addr_ok). Parser FSM, LED and reply logic stay in spi_cmd_ctrl.

Test Plan:
- Reset then LED ops: release rst_n; in one SS-low frame pulse recv_ready with 02, 03, 03, 01 -> led=1 after reset, then 0, 1, 0, 1 one cycle after each pulse; err_count=0.
- Write/read: frame 10,02,5A then 20,02; hold send_ready=0 -> regs_q[23:16]=5A; send_data=5A and held. Raise send_ready for 1 cycle -> send_data returns to A5 the next cycle.
- Bad address and opcode: with NUM_REGS=4, send 10,07,11 then 20,09 then 7F -> regs unchanged; reply=EE; err_count=3.
- Truncated frame: send 10,01, then raise ss_sync with no further byte -> state=S_OP, busy=0, err_count+1. Next frame 03 toggles led.
- Simultaneous abort: in S_WDATA, recv_ready with byte 33 on the same cycle ss_sync rises -> regs unchanged, err_count+1. Repeat from S_OP -> no increment.
- Saturation and async reset: issue 260 invalid opcodes -> err_count=FF and stays FF. Assert rst_n mid-frame between clock edges -> outputs reach their reset values before the next ext_clk edge.
